mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one external memory/MIO port between the pipeline's instruction-fetch and data-memory accesses and sequences the pipeline around it. Each pipeline step, it serialises the outstanding data access (MEM stage, older, served first) and instruction fetch over the single port, honouring the memory's ready handshake. It then pulses `cpu_en` for exactly one cycle so every pipeline register advances together. It sits between the CPU core (`cpu_en`, `PC_out`, `instruction_in`, `Address_out`, `Data_out`, `Data_in`, `mem_ifWriteMem`) and the bus/RAM.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum cycles to wait for `mem_ready` per access (4-bit counter; legal 1..15).
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on a timed-out access.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch needed this step (normally tied 1).
- `if_addr`  in  32  fetch address (`PC_out`).
- `if_rdata`  out  32  registered fetched instruction (`instruction_in`).
- `dm_req`  in  1  data access needed this step.
- `dm_we`  in  1  data access is a write (`mem_ifWriteMem`).
- `dm_addr`  in  32  data address (`Address_out`).
- `dm_wdata`  in  32  write data (`Data_out`).
- `dm_rdata`  out  32  registered load data (`Data_in`).
- `mem_req`  out  1  port request.
- `mem_we`  out  1  port write strobe.
- `mem_addr`  out  32  port address.
- `mem_wdata`  out  32  port write data.
- `mem_rdata`  in  32  port read data.
- `mem_ready`  in  1  access complete this cycle.
- `cpu_en`  out  1  one-cycle pipeline advance pulse.
- `bus_err`  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, DATA, FETCH, COMMIT.
- IDLE:
  - Latch `if_req`, `dm_req`, `dm_we`, and both addresses and write data.
  - If `dm_req`, go to DATA; else if `if_req`, go to FETCH; else stay in IDLE.
  - Requests are sampled only in IDLE. The core holds its inputs stable while `cpu_en` is low.
- DATA:
  - Drive `mem_req`=1, `mem_addr`=latched `dm_addr`, `mem_we`=latched `dm_we`, `mem_wdata`=latched wdata.
  - On `mem_ready`:
    - For a read, capture `mem_rdata` into `dm_rdata`. For a write, `dm_rdata` is unchanged.
    - Go to FETCH if a fetch was latched, else go to COMMIT.
- FETCH:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=latched `if_addr`.
  - On `mem_ready`, capture `mem_rdata` into `if_rdata` and go to COMMIT.
- COMMIT: `cpu_en`=1 for this cycle only, then return to IDLE.
- `mem_ready` is ignored in IDLE and COMMIT.
- All port outputs are registered and change only on state transitions.
  - `mem_req`/`mem_we` are low in IDLE and COMMIT.
  - `mem_addr`/`mem_wdata` hold their last value.
- Reset values: state IDLE; `mem_req`, `mem_we`, `cpu_en`, `bus_err` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0; wait counter 0.
- Reset mid-access: `mem_req` drops immediately (asynchronous), no capture occurs, and no `cpu_en` pulse is issued. Restart is from IDLE.

## Timing
- Zero-wait memory (`mem_ready` high in the first request cycle):
  - Step with data access: IDLE, DATA, FETCH, COMMIT = 4 cycles, `cpu_en` every 4th cycle.
  - Fetch-only step: 3 cycles.
- Each wait cycle with `mem_ready` low adds 1 cycle to that access.
- `if_rdata`/`dm_rdata` are valid from the COMMIT cycle and hold until the next capture.
- Data access always completes before the fetch in the same step. There is no reordering.
- `dm_req`=0 and `if_req`=0: the arbiter stays in IDLE and issues no `cpu_en` (pipeline frozen).

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A 4-bit counter clears on entry to DATA/FETCH and increments each cycle without `mem_ready`.
  - When it reaches `TIMEOUT`, the access is abandoned. For a read, `ERR_DATA` is captured; for a write, nothing is written.
  - `bus_err` pulses for 1 cycle and the FSM proceeds as if `mem_ready` had arrived.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter is present and the FSM waits indefinitely.
  - `bus_err` is tied 0.

## Test plan
- Zero-wait memory, `if_req`=1, `dm_req`=0, `if_addr`=0x0000_0004, `mem_rdata`=0x2008_0005 -> `mem_req` high 1 cycle at addr 0x4; `if_rdata`=0x2008_0005 and `cpu_en` pulses at cycle 3; repeats every 3 cycles.
- Load, `dm_addr`=0x0000_0040, `mem_rdata`=0x1234_5678 -> DATA precedes FETCH; `dm_rdata`=0x1234_5678; `mem_we`=0 throughout; `cpu_en` every 4 cycles.
- Store, `dm_we`=1, `dm_wdata`=0xCAFE_F00D, 3 wait states -> `mem_we`=1 with `mem_req` for 4 cycles at `dm_addr`; `dm_rdata` unchanged; `cpu_en` 3 cycles later than the zero-wait case.
- `rst` asserted in the second DATA wait cycle -> `mem_req`/`mem_we` drop without a clock edge; no `cpu_en`; after release, the FSM restarts from IDLE and completes normally.
- `MEM_ARB_TIMEOUT_EN` defined, `TIMEOUT`=15, `mem_ready` held low on a load -> 15 wait cycles, then `bus_err` pulse, `dm_rdata`=0xDEAD_BEEF, fetch proceeds, `cpu_en` pulses. With the macro undefined, the arbiter stays in DATA with no `cpu_en`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory/MIO port between the data access
// (MEM stage, served first) and the instruction fetch of each pipeline step,
// then pulses cpu_en for one cycle so all pipeline registers advance together.
// Optional feature macro: MEM_ARB_TIMEOUT_EN abandons an access that waits
// TIMEOUT cycles without mem_ready, returns ERR_DATA and pulses bus_err.
// Without the macro the arbiter waits indefinitely and bus_err is tied 0.
module mem_port_arbiter #(
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        cpu_en,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        FETCH  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        if_req_q, if_req_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        cpu_en_q, cpu_en_d;
    logic        access_done;
    logic        timed_out;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q, bus_err_d;

    // An access is abandoned once the wait counter has reached TIMEOUT and the memory still has not answered
    always_comb begin
        timed_out = 1'b0;
        if ((state_q == DATA || state_q == FETCH) && !mem_ready && wait_cnt_q == 4'(TIMEOUT)) begin
            timed_out = 1'b1;
        end
    end

    // Wait counter clears on every state change and counts cycles spent waiting for mem_ready
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = timed_out;
        if (state_d != state_q) begin
            wait_cnt_d = 4'd0;
        end else if ((state_q == DATA || state_q == FETCH) && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Timeout bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign bus_err        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Next-state logic: latch the step's requests in IDLE, serve data before fetch, then commit
    always_comb begin
        state_d     = state_q;
        if_req_d    = if_req_q;
        if_addr_d   = if_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        access_done = mem_ready || timed_out;
        case (state_q)
            IDLE: begin
                if_req_d  = if_req;
                if_addr_d = if_addr;
                if (dm_req) begin
                    state_d     = DATA;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_req) begin
                    state_d    = FETCH;
                    mem_addr_d = if_addr;
                end
            end
            DATA: begin
                if (access_done) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = timed_out ? ERR_DATA : mem_rdata;
                    end
                    if (if_req_q) begin
                        state_d    = FETCH;
                        mem_addr_d = if_addr_q;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            FETCH: begin
                if (access_done) begin
                    if_rdata_d = timed_out ? ERR_DATA : mem_rdata;
                    state_d    = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port strobes and the advance pulse are decoded from the state being entered so they are registered
    always_comb begin
        mem_req_d = (state_d == DATA) || (state_d == FETCH);
        mem_we_d  = 1'b0;
        if (state_d == DATA) begin
            mem_we_d = (state_q == IDLE) ? dm_we : mem_we_q;
        end
        cpu_en_d = (state_d == COMMIT);
    end

    // State and output registers; reset drops the port request immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            if_req_q    <= 1'b0;
            if_addr_q   <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
            cpu_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_req_q    <= if_req_d;
            if_addr_q   <= if_addr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            cpu_en_q    <= cpu_en_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign cpu_en    = cpu_en_q;

endmodule
